rh_dma_seq: RTL and testbench

RH11 DMA transfer sequencer. Sits between the RH11 register file (word count and bus address counters) and the KS10 backplane DMA interface. Moves one 36-bit word per drive strobe, requests the bus, and steps the word count and bus address after each completed bus cycle. Terminates on word-count overflow, non-existent memory (NXM), or controller clear.

---
 rtl/rh11_pkg.sv | 23 ++
 rtl/rh_bus_timer.sv | 27 ++
 rtl/rh_dma_seq.sv | 164 ++++++++++++++++
 tb/tb_rh_dma_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rh11_pkg.sv
// Shared types and constants for the RH11 DMA transfer sequencer.
package rh11_pkg;

    localparam int RH_WORD_W = 36;
    localparam int RH_WC_W   = 16;
    localparam logic [RH_WC_W-1:0] RH_WC_LAST = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_BREQ  = 3'd2,
        ST_BWAIT = 3'd3,
        ST_STEP  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } rh_state_e;

    // Word count is a negative count, so all-ones means this is the final word.
    function automatic logic is_last_word(input logic [RH_WC_W-1:0] wc);
        return wc == RH_WC_LAST;
    endfunction

endpackage

// File: rtl/rh_bus_timer.sv
// Loadable down-counter that bounds the bus-acknowledge wait; expired_o is high at zero.
module rh_bus_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/rh_dma_seq.sv
// RH11 DMA transfer sequencer: moves one 36-bit word per drive strobe across the
// KS10 DMA bus, stepping word count / bus address, with NXM timeout and abort.
module rh_dma_seq
    import rh11_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 devRESET,
    input  logic                 rhCLR,
    input  logic                 rhGO,
    input  logic                 rhREAD,
    input  logic [RH_WC_W-1:0]   rhWC,
    input  logic                 drvSTB,
    input  logic [RH_WORD_W-1:0] drvDATAI,
    output logic [RH_WORD_W-1:0] drvDATAO,
    output logic                 drvRDY,
    output logic                 devREQO,
    input  logic                 devACKI,
    output logic                 devWRU,
    input  logic [RH_WORD_W-1:0] devDATAI,
    output logic [RH_WORD_W-1:0] devDATAO,
    output logic                 rhINCWC,
    output logic                 rhINCBA,
    output logic                 rhBUSY,
    output logic                 rhDONE,
    output logic                 rhNXM
);

    // state | meaning
    // IDLE  | waiting for rhGO
    // FILL  | read: waiting for drive word
    // BREQ  | raising bus request, loading timeout
    // BWAIT | request held, waiting for ack or timeout
    // STEP  | word count / bus address increment pulse
    // DRAIN | write: buffer offered to drive
    // DONE  | end of transfer, rhDONE pulse follows

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    rh_state_e            state_q;
    logic [RH_WORD_W-1:0] buf_q;
    logic                 dir_q;
    logic                 last_q;
    logic                 req_q;
    logic                 inc_q;
    logic                 rdy_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 nxm_q;

    logic tmr_load_d;
    logic tmr_dec_d;
    logic tmr_expired;

    assign tmr_load_d = (state_q == ST_BREQ);
    assign tmr_dec_d  = (state_q == ST_BWAIT);

    rh_bus_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rstN       (rstN),
        .load_i     (tmr_load_d),
        .load_val_i (TW'(TIMEOUT)),
        .dec_i      (tmr_dec_d),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            dir_q   <= 1'b0;
            last_q  <= 1'b0;
            req_q   <= 1'b0;
            inc_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nxm_q   <= 1'b0;
        end else begin
            inc_q  <= 1'b0;
            done_q <= 1'b0;
            if (devRESET || rhCLR) begin
                state_q <= ST_IDLE;
                req_q   <= 1'b0;
                rdy_q   <= 1'b0;
                busy_q  <= 1'b0;
                nxm_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rhGO) begin
                            dir_q   <= rhREAD;
                            nxm_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= rhREAD ? ST_FILL : ST_BREQ;
                        end
                    end
                    ST_FILL: begin
                        if (drvSTB) begin
                            buf_q   <= drvDATAI;
                            state_q <= ST_BREQ;
                        end
                    end
                    ST_BREQ: begin
                        req_q   <= 1'b1;
                        state_q <= ST_BWAIT;
                    end
                    ST_BWAIT: begin
                        // An ack on the expiry clock still completes the cycle.
                        if (devACKI) begin
                            req_q   <= 1'b0;
                            inc_q   <= 1'b1;
                            state_q <= ST_STEP;
                            if (!dir_q) begin
                                buf_q <= devDATAI;
                            end
                        end else if (tmr_expired) begin
                            req_q   <= 1'b0;
                            nxm_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                    ST_STEP: begin
                        if (dir_q) begin
                            state_q <= is_last_word(rhWC) ? ST_DONE : ST_FILL;
                        end else begin
                            last_q  <= is_last_word(rhWC);
                            rdy_q   <= 1'b1;
                            state_q <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (drvSTB) begin
                            rdy_q   <= 1'b0;
                            state_q <= last_q ? ST_DONE : ST_BREQ;
                        end
                    end
                    ST_DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign drvDATAO = buf_q;
    assign devDATAO = buf_q;
    assign drvRDY   = rdy_q;
    assign devREQO  = req_q;
    assign devWRU   = dir_q;
    assign rhINCWC  = inc_q;
    assign rhINCBA  = inc_q;
    assign rhBUSY   = busy_q;
    assign rhDONE   = done_q;
    assign rhNXM    = nxm_q;

endmodule

// File: tb/tb_rh_dma_seq.sv
// Directed bench for rh_dma_seq: read, write, NXM timeout, abort and reset cases.
module tb_rh_dma_seq;

    logic        clk = 1'b0;
    logic        rstN;
    logic        devRESET;
    logic        rhCLR;
    logic        rhGO;
    logic        rhREAD;
    logic [15:0] rhWC;
    logic        drvSTB;
    logic [35:0] drvDATAI;
    logic [35:0] drvDATAO;
    logic        drvRDY;
    logic        devREQO;
    logic        devACKI;
    logic        devWRU;
    logic [35:0] devDATAI;
    logic [35:0] devDATAO;
    logic        rhINCWC;
    logic        rhINCBA;
    logic        rhBUSY;
    logic        rhDONE;
    logic        rhNXM;

    int checks = 0;
    int errors = 0;
    int n_incwc = 0;
    int n_incba = 0;
    int n_done = 0;
    int base_wc, base_ba, base_done;
    logic wc_pend = 1'b0;

    always #5 clk = ~clk;

    rh_dma_seq #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .devRESET (devRESET),
        .rhCLR    (rhCLR),
        .rhGO     (rhGO),
        .rhREAD   (rhREAD),
        .rhWC     (rhWC),
        .drvSTB   (drvSTB),
        .drvDATAI (drvDATAI),
        .drvDATAO (drvDATAO),
        .drvRDY   (drvRDY),
        .devREQO  (devREQO),
        .devACKI  (devACKI),
        .devWRU   (devWRU),
        .devDATAI (devDATAI),
        .devDATAO (devDATAO),
        .rhINCWC  (rhINCWC),
        .rhINCBA  (rhINCBA),
        .rhBUSY   (rhBUSY),
        .rhDONE   (rhDONE),
        .rhNXM    (rhNXM)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; models the register file's word-count
    // update landing one clock after the increment pulse, and tallies pulses.
    task automatic tick();
        @(negedge clk);
        if (wc_pend) rhWC = rhWC + 16'd1;
        wc_pend = rhINCWC;
        if (rhINCWC) n_incwc++;
        if (rhINCBA) n_incba++;
        if (rhDONE)  n_done++;
    endtask

    // Called in FILL with devACKI already high; walks FILL->BREQ->BWAIT->STEP.
    task automatic read_word(input logic [35:0] d, input bit last);
        drvSTB = 1'b1;
        drvDATAI = d;
        tick();
        drvSTB = 1'b0;
        drvDATAI = '0;
        chk("rd_breq_noreq", 64'(devREQO), 64'(0));
        tick();
        chk("rd_req", 64'(devREQO), 64'(1));
        chk("rd_wdata", 64'(devDATAO), 64'(d));
        chk("rd_wru", 64'(devWRU), 64'(1));
        tick();
        chk("rd_inc", 64'(rhINCWC), 64'(1));
        chk("rd_req_drop", 64'(devREQO), 64'(0));
        tick();
        chk("rd_inc_once", 64'(rhINCWC), 64'(0));
        chk("rd_busy", 64'(rhBUSY), 64'(1));
        chk("rd_done_early", 64'(rhDONE), 64'(0));
        if (last) begin
            tick();
            chk("rd_done", 64'(rhDONE), 64'(1));
            chk("rd_busy_end", 64'(rhBUSY), 64'(0));
        end
    endtask

    initial begin
        rstN = 1'b0;
        devRESET = 1'b0;
        rhCLR = 1'b0;
        rhGO = 1'b0;
        rhREAD = 1'b0;
        rhWC = 16'h0000;
        drvSTB = 1'b0;
        drvDATAI = '0;
        devACKI = 1'b0;
        devDATAI = '0;

        tick();
        tick();
        chk("rst_busy", 64'(rhBUSY), 64'(0));
        chk("rst_req", 64'(devREQO), 64'(0));
        chk("rst_nxm", 64'(rhNXM), 64'(0));
        chk("rst_rdy", 64'(drvRDY), 64'(0));
        chk("rst_wru", 64'(devWRU), 64'(0));
        chk("rst_buf", 64'(drvDATAO), 64'(0));
        rstN = 1'b1;
        tick();

        // Read direction, three words, immediate ack.
        base_wc = n_incwc; base_ba = n_incba; base_done = n_done;
        rhWC = 16'hFFFD;
        rhREAD = 1'b1;
        rhGO = 1'b1;
        devACKI = 1'b1;
        tick();
        rhGO = 1'b0;
        chk("rd_go_busy", 64'(rhBUSY), 64'(1));
        read_word(36'h1_2345_6789, 1'b0);
        read_word(36'hA_BCDE_F012, 1'b0);
        read_word(36'h5_5AA5_0FF0, 1'b1);
        devACKI = 1'b0;
        chk("rd_incwc_cnt", 64'(n_incwc - base_wc), 64'(3));
        chk("rd_incba_cnt", 64'(n_incba - base_ba), 64'(3));
        chk("rd_done_cnt", 64'(n_done - base_done), 64'(1));
        chk("rd_nxm", 64'(rhNXM), 64'(0));
        tick();

        // Write direction, single word.
        base_done = n_done;
        rhWC = 16'hFFFF;
        rhREAD = 1'b0;
        rhGO = 1'b1;
        tick();
        rhGO = 1'b0;
        chk("wr_busy", 64'(rhBUSY), 64'(1));
        chk("wr_wru", 64'(devWRU), 64'(0));
        chk("wr_breq_noreq", 64'(devREQO), 64'(0));
        tick();
        chk("wr_req", 64'(devREQO), 64'(1));
        devACKI = 1'b1;
        devDATAI = 36'o123456701234;
        drvSTB = 1'b1;
        drvDATAI = 36'hF_FFFF_FFFF;
        tick();
        devACKI = 1'b0;
        devDATAI = '0;
        drvSTB = 1'b0;
        drvDATAI = '0;
        chk("wr_inc", 64'(rhINCBA), 64'(1));
        chk("wr_req_drop", 64'(devREQO), 64'(0));
        chk("wr_buf", 64'(drvDATAO), 64'(36'o123456701234));
        tick();
        chk("wr_rdy", 64'(drvRDY), 64'(1));
        tick();
        chk("wr_rdy_hold", 64'(drvRDY), 64'(1));
        chk("wr_no_done", 64'(rhDONE), 64'(0));
        drvSTB = 1'b1;
        tick();
        drvSTB = 1'b0;
        chk("wr_rdy_drop", 64'(drvRDY), 64'(0));
        tick();
        chk("wr_done", 64'(rhDONE), 64'(1));
        chk("wr_busy_end", 64'(rhBUSY), 64'(0));
        chk("wr_done_cnt", 64'(n_done - base_done), 64'(1));
        tick();

        // NXM timeout with TIMEOUT=4: rhNXM rises 5 clocks after devREQO.
        base_wc = n_incwc; base_done = n_done;
        rhREAD = 1'b0;
        rhGO = 1'b1;
        tick();
        rhGO = 1'b0;
        tick();
        chk("nxm_req_rise", 64'(devREQO), 64'(1));
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("nxm_early", 64'(rhNXM), 64'(0));
            chk("nxm_req_hold", 64'(devREQO), 64'(1));
        end
        tick();
        chk("nxm_set", 64'(rhNXM), 64'(1));
        chk("nxm_req_drop", 64'(devREQO), 64'(0));
        tick();
        chk("nxm_done", 64'(rhDONE), 64'(1));
        chk("nxm_busy_end", 64'(rhBUSY), 64'(0));
        chk("nxm_no_inc", 64'(n_incwc - base_wc), 64'(0));
        chk("nxm_sticky", 64'(rhNXM), 64'(1));
        tick();
        rhGO = 1'b1;
        tick();
        rhGO = 1'b0;
        chk("nxm_go_clears", 64'(rhNXM), 64'(0));
        chk("nxm_go_busy", 64'(rhBUSY), 64'(1));
        rhCLR = 1'b1;
        tick();
        rhCLR = 1'b0;
        tick();

        // Controller clear during BWAIT; a late ack must be ignored.
        base_wc = n_incwc; base_done = n_done;
        rhREAD = 1'b0;
        rhGO = 1'b1;
        tick();
        rhGO = 1'b0;
        tick();
        tick();
        chk("clr_req_before", 64'(devREQO), 64'(1));
        rhCLR = 1'b1;
        tick();
        rhCLR = 1'b0;
        chk("clr_req", 64'(devREQO), 64'(0));
        chk("clr_busy", 64'(rhBUSY), 64'(0));
        devACKI = 1'b1;
        tick();
        devACKI = 1'b0;
        chk("clr_ack_ign_inc", 64'(rhINCWC), 64'(0));
        chk("clr_ack_ign_req", 64'(devREQO), 64'(0));
        tick();
        tick();
        chk("clr_no_done", 64'(n_done - base_done), 64'(0));
        chk("clr_no_inc", 64'(n_incwc - base_wc), 64'(0));

        // rhGO with devRESET in the same clock: abort wins.
        rhGO = 1'b1;
        devRESET = 1'b1;
        tick();
        rhGO = 1'b0;
        devRESET = 1'b0;
        chk("rstgo_busy", 64'(rhBUSY), 64'(0));
        tick();
        chk("rstgo_busy2", 64'(rhBUSY), 64'(0));
        chk("rstgo_req", 64'(devREQO), 64'(0));

        // Asynchronous reset in the middle of a read transfer.
        rhWC = 16'hFFF0;
        rhREAD = 1'b1;
        rhGO = 1'b1;
        tick();
        rhGO = 1'b0;
        drvSTB = 1'b1;
        drvDATAI = 36'h3_1415_9265;
        tick();
        drvSTB = 1'b0;
        tick();
        chk("arst_pre_req", 64'(devREQO), 64'(1));
        chk("arst_pre_buf", 64'(drvDATAO), 64'(36'h3_1415_9265));
        #2;
        rstN = 1'b0;
        #1;
        chk("arst_req", 64'(devREQO), 64'(0));
        chk("arst_busy", 64'(rhBUSY), 64'(0));
        chk("arst_wru", 64'(devWRU), 64'(0));
        chk("arst_buf", 64'(drvDATAO), 64'(0));
        tick();
        rstN = 1'b1;
        tick();
        chk("arst_idle", 64'(rhBUSY), 64'(0));
        rhREAD = 1'b0;
        rhGO = 1'b1;
        tick();
        rhGO = 1'b0;
        chk("arst_restart", 64'(rhBUSY), 64'(1));
        devRESET = 1'b1;
        tick();
        devRESET = 1'b0;
        chk("arst_abort", 64'(rhBUSY), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
